// File: rtl/snd_vol_ramp_ctrl.sv
// snd_vol_ramp_ctrl: play/stop sequencer for the snd_volume gain stage.
// Drives VOLUME and COMMAND so that the gain fades in on play and fades out
// on stop. Only with SND_VOL_RAMP_EN defined does the gain move one LSB per
// STEP_DIV sample strobes. Without the macro, each fade phase lasts a single
// cycle and the gain jumps straight to its end value.
module snd_vol_ramp_ctrl #(
  parameter int unsigned STEP_DIV = 16
) (
  input  logic       ACLK,
  input  logic       ARST,
  input  logic       PLAY,
  input  logic       STOP,
  input  logic [7:0] TARGET_VOL,
  input  logic       SMPL_VALID,
  output logic [7:0] VOLUME,
  output logic [1:0] COMMAND,
  output logic       BUSY,
  output logic       FADE_DONE,
  output logic [2:0] STATE
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FADE_IN  = 3'd1,
    RUN      = 3'd2,
    FADE_OUT = 3'd3
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] vol_nxt;
  logic [1:0] cmd_nxt;
  logic       busy_nxt;
  logic       done_nxt;

  // vol_track: the gain one step closer to TARGET_VOL (FADE_IN/RUN).
  // vol_fade:  the gain one step closer to zero (FADE_OUT).
  logic [7:0] vol_track;
  logic [7:0] vol_fade;

`ifdef SND_VOL_RAMP_EN
  localparam int unsigned DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(STEP_DIV - 1);

  logic [DW-1:0] div;
  logic          tick;

  assign tick = SMPL_VALID && (div == DIV_LAST);

  // Sample divider: restarts on every state change so each fade begins on a full step period
  always_ff @(posedge ACLK) begin
    if (ARST) begin
      div <= '0;
    end else if (state_nxt != state) begin
      div <= '0;
    end else if (SMPL_VALID) begin
      div <= tick ? '0 : div + DW'(1);
    end
  end

  // One-LSB step toward the requested gain, taken only on a divider tick
  always_comb begin
    vol_track = VOLUME;
    if (tick) begin
      if (VOLUME < TARGET_VOL) begin
        vol_track = VOLUME + 8'd1;
      end else if (VOLUME > TARGET_VOL) begin
        vol_track = VOLUME - 8'd1;
      end
    end
  end

  assign vol_fade = (tick && (VOLUME != 8'd0)) ? VOLUME - 8'd1 : VOLUME;
`else
  // Without ramping the gain lands on its end value in one cycle.
  // The sample strobe and the step divisor are not needed in this build.
  logic unused_cfg;
  assign unused_cfg = ^{SMPL_VALID, 9'(STEP_DIV)};
  assign vol_track  = TARGET_VOL;
  assign vol_fade   = 8'd0;
`endif

  // Next-state and next-output decode; STOP always takes priority over PLAY
  always_comb begin
    state_nxt = state;
    vol_nxt   = VOLUME;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        vol_nxt = 8'd0;
        if (PLAY && !STOP) begin
          state_nxt = FADE_IN;
        end
      end
      FADE_IN: begin
        if (STOP) begin
          state_nxt = FADE_OUT;
        end else begin
          vol_nxt = vol_track;
          if (vol_track == TARGET_VOL) begin
            state_nxt = RUN;
            done_nxt  = 1'b1;
          end
        end
      end
      RUN: begin
        if (STOP) begin
          state_nxt = FADE_OUT;
        end else begin
          vol_nxt = vol_track;
        end
      end
      FADE_OUT: begin
        if (PLAY && !STOP) begin
          state_nxt = FADE_IN;
        end else begin
          vol_nxt = vol_fade;
          if (vol_fade == 8'd0) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        vol_nxt   = 8'd0;
      end
    endcase
    cmd_nxt  = (state_nxt == IDLE) ? 2'b00 : 2'b01;
    busy_nxt = (state_nxt == FADE_IN) || (state_nxt == FADE_OUT);
  end

  // Output and state registers; every output is driven from a flop
  always_ff @(posedge ACLK) begin
    if (ARST) begin
      state     <= IDLE;
      VOLUME    <= 8'd0;
      COMMAND   <= 2'b00;
      BUSY      <= 1'b0;
      FADE_DONE <= 1'b0;
    end else begin
      state     <= state_nxt;
      VOLUME    <= vol_nxt;
      COMMAND   <= cmd_nxt;
      BUSY      <= busy_nxt;
      FADE_DONE <= done_nxt;
    end
  end

  assign STATE = state;

endmodule

// File: tb/tb_snd_vol_ramp_ctrl.sv
// Testbench for snd_vol_ramp_ctrl. Works with or without SND_VOL_RAMP_EN.
// The bench builds its own picture of the expected gain, phase, done pulse
// and command from the play/stop rules. It then checks every DUT output
// after every clock.
module tb_snd_vol_ramp_ctrl;

  localparam int DIV = 2;
`ifdef SND_VOL_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif

  logic       ACLK = 1'b0;
  logic       ARST;
  logic       PLAY;
  logic       STOP;
  logic [7:0] TARGET_VOL;
  logic       SMPL_VALID;
  logic [7:0] VOLUME;
  logic [1:0] COMMAND;
  logic       BUSY;
  logic       FADE_DONE;
  logic [2:0] STATE;

  int total = 0;
  int bad   = 0;

  // Reference picture: phase 0=idle, 1=fading in, 2=running, 3=fading out
  int m_phase = 0;
  int m_gain  = 0;
  int m_smpls = 0;
  bit m_done  = 1'b0;
  int curTgt  = 4;

  snd_vol_ramp_ctrl #(.STEP_DIV(DIV)) dut (
    .ACLK       (ACLK),
    .ARST       (ARST),
    .PLAY       (PLAY),
    .STOP       (STOP),
    .TARGET_VOL (TARGET_VOL),
    .SMPL_VALID (SMPL_VALID),
    .VOLUME     (VOLUME),
    .COMMAND    (COMMAND),
    .BUSY       (BUSY),
    .FADE_DONE  (FADE_DONE),
    .STATE      (STATE)
  );

  always #5 ACLK = ~ACLK;

  function automatic int toward(input int cur, input int goal, input bit stepNow);
    if (!stepNow) return cur;
    if (cur < goal) return cur + 1;
    if (cur > goal) return cur - 1;
    return cur;
  endfunction

  // Advance the reference by one clock, using the request/strobe values seen at that edge
  task automatic modelStep(input bit rst, input bit p, input bit s, input int tgt, input bit v);
    int  np;
    int  ng;
    bit  dn;
    bit  stepNow;
    if (rst) begin
      m_phase = 0;
      m_gain  = 0;
      m_smpls = 0;
      m_done  = 1'b0;
      return;
    end
    np      = m_phase;
    ng      = m_gain;
    dn      = 1'b0;
    stepNow = v && (((m_smpls + 1) % DIV) == 0);
    case (m_phase)
      0: begin
        ng = 0;
        if (p && !s) np = 1;
      end
      1: begin
        if (s) np = 3;
        else begin
          ng = RAMP ? toward(m_gain, tgt, stepNow) : tgt;
          if (ng == tgt) begin
            np = 2;
            dn = 1'b1;
          end
        end
      end
      2: begin
        if (s) np = 3;
        else ng = RAMP ? toward(m_gain, tgt, stepNow) : tgt;
      end
      default: begin
        if (p && !s) np = 1;
        else begin
          ng = RAMP ? toward(m_gain, 0, stepNow) : 0;
          if (ng == 0) begin
            np = 0;
            dn = 1'b1;
          end
        end
      end
    endcase
    if (np != m_phase) m_smpls = 0;
    else if (v) m_smpls = m_smpls + 1;
    m_phase = np;
    m_gain  = ng;
    m_done  = dn;
  endtask

  task automatic checkOutput(input string tag);
    logic [1:0] expCmd;
    logic       expBusy;
    expCmd  = (m_phase != 0) ? 2'b01 : 2'b00;
    expBusy = (m_phase == 1) || (m_phase == 3);
    total++;
    assert (VOLUME === 8'(m_gain))
      else begin bad++; $error("FAIL %s VOLUME got %0d expected %0d", tag, VOLUME, m_gain); end
    total++;
    assert (STATE === 3'(m_phase))
      else begin bad++; $error("FAIL %s STATE got %0d expected %0d", tag, STATE, m_phase); end
    total++;
    assert (COMMAND === expCmd)
      else begin bad++; $error("FAIL %s COMMAND got %0d expected %0d", tag, COMMAND, expCmd); end
    total++;
    assert (BUSY === expBusy)
      else begin bad++; $error("FAIL %s BUSY got %0d expected %0d", tag, BUSY, expBusy); end
    total++;
    assert (FADE_DONE === m_done)
      else begin bad++; $error("FAIL %s FADE_DONE got %0d expected %0d", tag, FADE_DONE, m_done); end
  endtask

  task automatic checkConst(input string tag, input int act, input int exp);
    total++;
    assert (act === exp)
      else begin bad++; $error("FAIL %s got %0d expected %0d", tag, act, exp); end
  endtask

  // Drive one cycle of inputs, clock it, update the reference and compare everything
  task automatic applyStimulus(input bit rst, input bit p, input bit s, input int tgt,
                               input bit v, input string tag);
    ARST       = rst;
    PLAY       = p;
    STOP       = s;
    TARGET_VOL = 8'(tgt);
    SMPL_VALID = v;
    @(posedge ACLK);
    modelStep(rst, p, s, tgt, v);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    ARST = 1'b1; PLAY = 1'b0; STOP = 1'b0; TARGET_VOL = 8'd0; SMPL_VALID = 1'b0;
    $display("[TB] start, ramp=%0d step_div=%0d", RAMP, DIV);

    // Reset state
    applyStimulus(1, 0, 0, 4, 1, "reset");
    applyStimulus(1, 0, 0, 4, 1, "reset2");
    checkConst("reset_volume", VOLUME, 0);
    checkConst("reset_cmd", COMMAND, 0);
    applyStimulus(0, 0, 0, 4, 1, "idle");

    // PLAY and STOP together in idle: nothing happens
    applyStimulus(0, 1, 1, 4, 1, "playstop_idle");
    checkConst("playstop_state", STATE, 0);
    checkConst("playstop_done", FADE_DONE, 0);
    applyStimulus(0, 0, 0, 4, 1, "playstop_after");

`ifdef SND_VOL_RAMP_EN
    // Fade in to 4 with a strobe every cycle: one step every two cycles
    applyStimulus(0, 1, 0, 4, 1, "fadein_req");
    checkConst("fadein_cmd", COMMAND, 1);
    for (int k = 2; k <= 9; k++) begin
      applyStimulus(0, 0, 0, 4, 1, "fadein");
      if (k % 2 == 1) checkConst("fadein_vol", VOLUME, (k - 1) / 2);
    end
    checkConst("fadein_run", STATE, 2);
    checkConst("fadein_done", FADE_DONE, 1);
    checkConst("fadein_busy", BUSY, 0);

    // Stop from 4, then restart at gain 2 toward 4
    applyStimulus(0, 0, 1, 4, 1, "fadeout_req");
    for (int k = 0; k < 4; k++) applyStimulus(0, 0, 0, 4, 1, "fadeout");
    checkConst("fadeout_vol2", VOLUME, 2);
    applyStimulus(0, 1, 0, 4, 1, "replay_req");
    for (int k = 0; k < 5; k++) applyStimulus(0, 0, 0, 4, 1, "replay");
    checkConst("replay_vol", VOLUME, 4);

    // Track a lower target in RUN, then freeze with no strobes
    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 1, 1, "track");
    for (int k = 0; k < 10; k++) applyStimulus(0, 0, 0, 1, 0, "frozen");
    for (int k = 0; k < 6; k++) applyStimulus(0, 0, 0, 1, 1, "track2");
    checkConst("track_vol", VOLUME, 1);

    // Fade out to zero
    applyStimulus(0, 0, 1, 1, 1, "stop_req");
    for (int k = 0; k < 4; k++) applyStimulus(0, 0, 0, 1, 1, "stop");
    checkConst("stop_idle", STATE, 0);
`else
    // Immediate mode: gain jumps to the target two cycles after PLAY
    applyStimulus(0, 1, 0, 200, 1, "jump_req");
    checkConst("jump_fadein", STATE, 1);
    applyStimulus(0, 0, 0, 200, 1, "jump");
    checkConst("jump_vol", VOLUME, 200);
    checkConst("jump_run", STATE, 2);
    checkConst("jump_done", FADE_DONE, 1);
    applyStimulus(0, 0, 0, 37, 1, "follow");
    applyStimulus(0, 0, 0, 37, 0, "follow2");
    checkConst("follow_vol", VOLUME, 37);
    applyStimulus(0, 0, 1, 37, 1, "cut_req");
    applyStimulus(0, 0, 0, 37, 1, "cut");
    checkConst("cut_vol", VOLUME, 0);
    checkConst("cut_done", FADE_DONE, 1);
    checkConst("cut_cmd", COMMAND, 0);
`endif

    // Reset in the middle of a fade in
    applyStimulus(0, 1, 0, 9, 1, "abort_req");
    for (int k = 0; k < 4; k++) applyStimulus(0, 0, 0, 9, 1, "abort_fade");
    applyStimulus(1, 0, 0, 9, 1, "abort_rst");
    checkConst("abort_state", STATE, 0);
    checkConst("abort_vol", VOLUME, 0);
    checkConst("abort_done", FADE_DONE, 0);

    // Random requests, targets and strobes against the reference
    for (int i = 0; i < 1500; i++) begin
      bit r;
      bit p;
      bit s;
      bit v;
      r = ($urandom_range(0, 199) == 0);
      p = ($urandom_range(0, 7) == 0);
      s = ($urandom_range(0, 11) == 0);
      v = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0)
        curTgt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 6));
      applyStimulus(r, p, s, curTgt, v, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
